// File: rtl/tx_fcs_append.sv
// tx_fcs_append: TX-path stage after the CRC32 engine. Forwards a 32-bit
// AXI-Stream frame unchanged and appends the 4-byte Ethernet FCS directly
// after the last payload byte. FCS bytes fill the unused lanes of the last
// beat; whatever does not fit goes out in one extra (SPILL) beat.
// Optional build macro TX_FCS_PAD_EN: short frames are zero-padded up to
// MIN_FRAME_BYTES before the FCS. Middle beats of a frame are expected to
// carry all four lanes; only the last beat may be partial.
module tx_fcs_append #(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF
`ifdef TX_FCS_PAD_EN
  , parameter int        MIN_FRAME_BYTES = 60
`endif
) (
  input  logic                    clk,
  input  logic                    i_reset_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  typedef enum logic [1:0] {ST_DATA = 2'd0, ST_SPILL = 2'd1, ST_PAD = 2'd2} state_t;

  // Reflected IEEE 802.3 CRC, lanes folded in order 0..3, only enabled lanes.
  function automatic logic [31:0] crc_beat(input logic [31:0] crc_in,
                                           input logic [31:0] data,
                                           input logic [3:0]  keep);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (keep[i]) begin
        c = c ^ {24'd0, data[8*i +: 8]};
        for (int j = 0; j < 8; j++) begin
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  state_t      state_reg;
  logic [31:0] crc_reg;
  logic [31:0] data_reg;
  logic [3:0]  keep_reg;
  logic        valid_reg;
  logic        last_reg;
  logic [31:0] spill_data_reg;
  logic [3:0]  spill_keep_reg;

  logic        out_free;
  logic        accept;
  logic [31:0] keep_mask;
  logic [31:0] data_eff;
  logic [2:0]  beat_bytes;
  logic [2:0]  k_eff;
  logic [3:0]  keep_eff;
  logic [31:0] crc_din;
  logic [3:0]  crc_kin;
  logic [31:0] crc_next;
  logic [31:0] fcs;

  // Byte-enable expansion; used to clear unused lanes before FCS merging.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign keep_mask[8*gi +: 8] = {8{s_axis_tkeep[gi]}};
  end

  assign data_eff = s_axis_tdata & keep_mask;
  assign out_free = !valid_reg || m_axis_tready;
  assign accept   = s_axis_tvalid && s_axis_tready;

  // Number of valid bytes in the incoming beat.
  always_comb begin
    beat_bytes = 3'd0;
    for (int i = 0; i < 4; i++) begin
      beat_bytes = beat_bytes + {2'd0, s_axis_tkeep[i]};
    end
  end

`ifdef TX_FCS_PAD_EN
  localparam logic [15:0] MIN_BYTES = 16'(MIN_FRAME_BYTES);
  logic [15:0] byte_cnt_reg;
  logic [15:0] pad_left_reg;
  logic [15:0] byte_sum;
  logic        pad_need;
  logic        pad_more;

  assign byte_sum = byte_cnt_reg + {13'd0, beat_bytes};
  // A short frame's last beat is zero-filled to all four lanes.
  assign pad_need = s_axis_tlast && (byte_sum < MIN_BYTES);
  // More zero beats still needed after that filled last beat.
  assign pad_more = (byte_cnt_reg + 16'd4) < MIN_BYTES;
  assign k_eff    = pad_need ? 3'd4 : beat_bytes;
  assign keep_eff = pad_need ? 4'hF : s_axis_tkeep;
  assign crc_din  = (state_reg == ST_PAD) ? 32'd0 : data_eff;
  assign crc_kin  = (state_reg == ST_PAD) ? 4'hF : keep_eff;
`else
  assign k_eff    = beat_bytes;
  assign keep_eff = s_axis_tkeep;
  assign crc_din  = data_eff;
  assign crc_kin  = keep_eff;
`endif

  assign crc_next = crc_beat(crc_reg, crc_din, crc_kin);
  assign fcs      = ~crc_next;

  assign s_axis_tready = i_reset_n && (state_reg == ST_DATA) && out_free;
  assign m_axis_tdata  = data_reg;
  assign m_axis_tkeep  = keep_reg;
  assign m_axis_tvalid = valid_reg;
  assign m_axis_tlast  = last_reg;

  // Frame FSM, running CRC and the one-beat output register.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_reg      <= ST_DATA;
      crc_reg        <= CRC_INIT;
      data_reg       <= 32'd0;
      keep_reg       <= 4'd0;
      valid_reg      <= 1'b0;
      last_reg       <= 1'b0;
      spill_data_reg <= 32'd0;
      spill_keep_reg <= 4'd0;
`ifdef TX_FCS_PAD_EN
      byte_cnt_reg   <= 16'd0;
      pad_left_reg   <= 16'd0;
`endif
    end else begin
      if (valid_reg && m_axis_tready) begin
        valid_reg <= 1'b0;
      end
      case (state_reg)
        ST_DATA: begin
          if (accept) begin
            valid_reg <= 1'b1;
            if (!s_axis_tlast) begin
              data_reg <= s_axis_tdata;
              keep_reg <= s_axis_tkeep;
              last_reg <= 1'b0;
              crc_reg  <= crc_next;
`ifdef TX_FCS_PAD_EN
              byte_cnt_reg <= (byte_sum >= MIN_BYTES) ? MIN_BYTES : byte_sum;
`endif
            end
`ifdef TX_FCS_PAD_EN
            else if (pad_need && pad_more) begin
              data_reg     <= data_eff;
              keep_reg     <= 4'hF;
              last_reg     <= 1'b0;
              crc_reg      <= crc_next;
              pad_left_reg <= MIN_BYTES - byte_cnt_reg - 16'd4;
              byte_cnt_reg <= 16'd0;
              state_reg    <= ST_PAD;
            end
`endif
            else begin
              // Payload in lanes 0..k-1, leading FCS bytes in the rest.
              data_reg       <= data_eff | (fcs << {k_eff, 3'b000});
              keep_reg       <= 4'hF;
              crc_reg        <= CRC_INIT;
              spill_data_reg <= fcs >> {3'd4 - k_eff, 3'b000};
              // Contiguous keep with k lanes is exactly the spill keep.
              spill_keep_reg <= keep_eff;
`ifdef TX_FCS_PAD_EN
              byte_cnt_reg   <= 16'd0;
`endif
              if (k_eff == 3'd0) begin
                last_reg <= 1'b1;
              end else begin
                last_reg  <= 1'b0;
                state_reg <= ST_SPILL;
              end
            end
          end
        end
        ST_SPILL: begin
          if (out_free) begin
            data_reg  <= spill_data_reg;
            keep_reg  <= spill_keep_reg;
            last_reg  <= 1'b1;
            valid_reg <= 1'b1;
            state_reg <= ST_DATA;
          end
        end
`ifdef TX_FCS_PAD_EN
        ST_PAD: begin
          if (out_free) begin
            data_reg  <= 32'd0;
            keep_reg  <= 4'hF;
            last_reg  <= 1'b0;
            valid_reg <= 1'b1;
            if (pad_left_reg <= 16'd4) begin
              crc_reg        <= CRC_INIT;
              spill_data_reg <= fcs;
              spill_keep_reg <= 4'hF;
              state_reg      <= ST_SPILL;
            end else begin
              crc_reg      <= crc_next;
              pad_left_reg <= pad_left_reg - 16'd4;
            end
          end
        end
`endif
        default: state_reg <= ST_DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_fcs_append.sv
// Bench for tx_fcs_append: byte-level reference model (payload, optional
// zero pad, table-driven CRC, chunked into 4-byte beats) feeding a queue that
// one negedge compare process checks every output transfer against.
module tb_tx_fcs_append;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] s_axis_tdata = 32'd0;
  logic [3:0]  s_axis_tkeep = 4'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;

`ifdef TX_FCS_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  always #5 clk = ~clk;

  tx_fcs_append dut (
    .clk           (clk),
    .i_reset_n     (i_reset_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       model_q[$];
  logic [7:0]  pl[$];
  logic [31:0] crc_tbl[256];
  int          vectors = 0;
  int          miscompares = 0;
  int          ready_mode = 0;
  int          frame_no = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fcs_of_bytes(input logic [7:0] s[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (s[i]) c = crc_tbl[c[7:0] ^ s[i]] ^ (c >> 8);
    return ~c;
  endfunction

  // Whole-frame reference: byte stream -> 4-byte beats, tlast on the final one.
  task automatic model_frame(input bit pad);
    logic [7:0]  s[$];
    logic [31:0] f;
    beat_t       b;
    s = pl;
    if (pad) while (s.size() < 60) s.push_back(8'h00);
    f = fcs_of_bytes(s);
    for (int i = 0; i < 4; i++) s.push_back(f[8*i +: 8]);
    model_q.delete();
    for (int i = 0; i < s.size(); i += 4) begin
      b = '0;
      for (int j = 0; j < 4; j++) begin
        if (i + j < s.size()) begin
          b.d[8*j +: 8] = s[i+j];
          b.k[j] = 1'b1;
        end
      end
      b.l = (i + 4 >= s.size());
      model_q.push_back(b);
    end
  endtask

  task automatic load_str(input string s);
    pl.delete();
    for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int   n;
    logic acc;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    vectors++;
    if (!acc) begin
      miscompares++;
      $display("FAIL accept_timeout: got no s_axis_tready within %0d cycles, expected accept", n);
    end
  endtask

  task automatic send_frame(input bit use_model, input bit empty_tail, input int gap_max);
    int          n, full, k;
    logic [31:0] d;
    logic [3:0]  kp;
    n = pl.size();
    if (use_model) begin
      model_frame(PAD);
      foreach (model_q[i]) exp_q.push_back(model_q[i]);
    end
    if (n % 4 != 0) begin
      full = n / 4; k = n % 4;
    end else if (empty_tail || n == 0) begin
      full = n / 4; k = 0;
    end else begin
      full = n / 4 - 1; k = 4;
    end
    for (int b = 0; b < full; b++) begin
      d = {pl[4*b+3], pl[4*b+2], pl[4*b+1], pl[4*b]};
      drive_beat(d, 4'hF, 1'b0);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
    d = $urandom();
    for (int i = 0; i < k; i++) d[8*i +: 8] = pl[4*full + i];
    kp = 4'hF >> (4 - k);
    drive_beat(d, kp, 1'b1);
    frame_no++;
    $display("frame %0d: %0d payload bytes, tail keep %h, ready mode %0d", frame_no, n, kp, ready_mode);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d expected beats still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_literal_123456789();
    if (PAD) begin
      load_str("123456789");
      model_frame(1'b1);
      foreach (model_q[i]) exp_q.push_back(model_q[i]);
    end else begin
      exp_q.push_back('{32'h34333231, 4'hF, 1'b0});
      exp_q.push_back('{32'h38373635, 4'hF, 1'b0});
      exp_q.push_back('{32'hF4392639, 4'hF, 1'b0});
      exp_q.push_back('{32'h000000CB, 4'h1, 1'b1});
    end
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check32("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    check32("rst_tdata", m_axis_tdata, 32'd0);
    check32("rst_tkeep", {28'd0, m_axis_tkeep}, 32'd0);
    check32("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
    check32("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
  endtask

  // Downstream ready pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ~m_axis_tready;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Output checker: hold-while-stalled and every transferred beat.
  initial begin
    beat_t cur, prev, e;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (i_reset_n) begin
        if (prev_stall) begin
          vectors++;
          if (!m_axis_tvalid || cur != prev) begin
            miscompares++;
            $display("FAIL hold: got v=%b %h/%h/%b expected v=1 %h/%h/%b",
                     m_axis_tvalid, cur.d, cur.k, cur.l, prev.d, prev.k, prev.l);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL extra_beat: got %h/%h/%b expected no beat", cur.d, cur.k, cur.l);
          end else begin
            e = exp_q.pop_front();
            if (cur != e) begin
              miscompares++;
              $display("FAIL beat: got %h/%h/%b expected %h/%h/%b", cur.d, cur.k, cur.l, e.d, e.k, e.l);
            end
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev = cur;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c, d1, d2;
    int          n;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[i] = c;
    end

    // Pin the model with hand-computed values.
    load_str("123456789");
    check32("model_check_value", fcs_of_bytes(pl), 32'hCBF43926);
    model_frame(1'b0);
    check32("model_9b_beats", model_q.size(), 32'd4);
    check32("model_9b_beat2", model_q[2].d, 32'hF4392639);
    check32("model_9b_beat3", {model_q[3].d[27:0], model_q[3].k}, {28'h00000CB, 4'h1});
    load_str("12345678");
    model_frame(1'b0);
    check32("model_8b_beats", model_q.size(), 32'd3);
    pl.delete();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    model_frame(1'b1);
    check32("model_pad_beats", model_q.size(), 32'd16);
    check32("model_pad_beat0", model_q[0].d, 32'h04030201);
    check32("model_pad_beat14", model_q[14].d, 32'd0);

    // Reset state.
    i_reset_n = 1'b0;
    repeat (3) @(posedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;

    // "123456789" with literal expectations, ready always high.
    ready_mode = 0;
    push_literal_123456789();
    load_str("123456789");
    send_frame(1'b0, 1'b0, 0);
    wait_drain();

    // 8-byte frame ending with a full beat: FCS occupies its own final beat.
    load_str("12345678");
    send_frame(1'b1, 1'b0, 0);
    wait_drain();

    // Same 9-byte frame with ready toggling.
    ready_mode = 1;
    push_literal_123456789();
    load_str("123456789");
    send_frame(1'b0, 1'b0, 0);
    wait_drain();

    // Back-to-back frames, second follows the first's spill immediately.
    ready_mode = 0;
    load_str("123456789");
    send_frame(1'b1, 1'b0, 0);
    load_str("ABCDEFGHIJK");
    send_frame(1'b1, 1'b0, 0);
    wait_drain();

    // Empty last beat and empty frame.
    load_str("abcdefgh");
    send_frame(1'b1, 1'b1, 0);
    pl.delete();
    send_frame(1'b1, 1'b1, 0);
    wait_drain();

    // Reset mid-frame after two forwarded beats.
    d1 = $urandom();
    d2 = $urandom();
    exp_q.push_back('{d1, 4'hF, 1'b0});
    exp_q.push_back('{d2, 4'hF, 1'b0});
    drive_beat(d1, 4'hF, 1'b0);
    drive_beat(d2, 4'hF, 1'b0);
    wait_drain();
    i_reset_n = 1'b0;
    repeat (2) @(posedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    push_literal_123456789();
    load_str("123456789");
    send_frame(1'b0, 1'b0, 0);
    wait_drain();

    // Short 4-byte frame (padded to 60 bytes when the pad feature is built).
    pl.delete();
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(1'b1, 1'b0, 0);
    wait_drain();

    // Randomized frames, lengths, tail keeps, gaps and downstream stalls.
    for (int f = 0; f < 25; f++) begin
      ready_mode = $urandom_range(0, 2);
      n = $urandom_range(0, 70);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom()));
      send_frame(1'b1, 1'($urandom_range(0, 1)), 2);
    end
    wait_drain();

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_fcs_append.md
Name: tx_fcs_append

Overview:
- TX-path stage directly downstream of the CRC32 engine in the 10G MAC.
- Accepts a frame as a 32-bit AXI-Stream, forwards it unchanged, and appends the 4-byte Ethernet FCS immediately after the last payload byte.
- Packs FCS bytes into unused lanes of the last beat and spills the remainder into one extra beat.
- Feeds the MAC framer / XGMII encoder.

Parameters:
- DATA_WIDTH, 32, stream width in bits; only 32 is supported.
- CRC_INIT, 32'hFFFFFFFF, CRC register value at start of each frame.
- MIN_FRAME_BYTES, 60, minimum pre-FCS frame length; used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock
- i_reset_n  input  1  synchronous active-low reset
- s_axis_tdata  input  32  payload; byte 0 = [7:0], sent first
- s_axis_tkeep  input  4  byte enables; contiguous from bit 0
- s_axis_tvalid  input  1  upstream beat valid
- s_axis_tlast  input  1  last payload beat of frame
- s_axis_tready  output  1  block accepts beat
- m_axis_tdata  output  32  payload + FCS
- m_axis_tkeep  output  4  output byte enables
- m_axis_tvalid  output  1  output beat valid
- m_axis_tlast  output  1  last beat (carries final FCS byte)
- m_axis_tready  input  1  downstream ready

Behaviour:
- Reset: clk and reset i_reset_n, synchronous, active-low.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, s_axis_tready=0 while in reset.
  - State=DATA, CRC=CRC_INIT.
- CRC: reflected IEEE 802.3 polynomial 0xEDB88320, byte-serial order lane 0..3, only lanes with tkeep=1.
  - FCS = ~CRC.
  - FCS byte i = FCS[8i+7:8i], transmitted in increasing i.
  - CRC is reset to CRC_INIT after the last FCS byte is accepted downstream.
- Output register: one beat, latency one cycle from accept to m_axis_tvalid.
  - Output register loads when it is empty or m_axis_tready=1.
- s_axis_tready = (state==DATA) && (!m_axis_tvalid || m_axis_tready).
- States:
  - DATA: forward beats unchanged with tlast forced to 0. On an accepted beat with s_axis_tlast=1 and k = popcount(tkeep):
    - k in 1..4: output beat lanes 0..k-1 = data, lanes k..3 = FCS bytes 0..3-k, keep=4'hF. Go to SPILL with k FCS bytes remaining.
    - k=0: output beat = FCS bytes 0..3, keep=4'hF, tlast=1. Stay in DATA.
  - SPILL: when the output register frees, emit lanes 0..k-1 = FCS bytes 4-k..3, keep = (1<<k)-1, upper lanes 0, tlast=1. Return to DATA.
- s_axis_tready is low in SPILL (and PAD, if compiled in).
- Back-to-back frames: a new frame may be accepted the cycle after the SPILL beat is accepted downstream.
- m_axis_tvalid, once high, holds with stable data/keep/last until m_axis_tready=1.
- Reset mid-frame: partial frame discarded, no tlast emitted, CRC reinitialised. Downstream handles the truncated frame.
- Non-contiguous tkeep is illegal; behaviour is undefined and carries no checker requirement.

Optional Feature:
- Macro TX_FCS_PAD_EN.
- Defined:
  - Block counts payload bytes per frame.
  - If the frame ends with fewer than MIN_FRAME_BYTES, state PAD is entered: zero bytes are appended (and folded into the CRC) until exactly MIN_FRAME_BYTES precede the FCS. The FCS is then packed/spilled as above.
  - The last payload beat is padded to 4 lanes with zeros.
  - Frames of MIN_FRAME_BYTES or more are untouched.
- Undefined: no counter or PAD state; short frames pass through with FCS only.

Test Plan:
- "123456789" in 3 beats (0x34333231 kF, 0x38373635 kF, 0x00000039 k1 last) -> outputs 0x34333231, 0x38373635, 0xF4392639 kF, then 0x000000CB k1 tlast. FCS bytes are 26 39 F4 CB (CRC 0xCBF43926).
- 8-byte frame "12345678" ending kF -> third beat = FCS bytes 0..3 kF tlast. FCS must match the software reference model; no fourth beat.
- Same 9-byte frame with m_axis_tready toggling 1010... -> identical beat sequence, no drops or duplicates, tvalid/data stable while stalled.
- Two back-to-back frames, the second starting immediately after the first's SPILL -> second FCS unaffected by the first (CRC reinitialised).
- Reset asserted mid-frame after 2 beats, then "123456789" sent -> only the second frame's output, correct FCS 0xCBF43926.
- TX_FCS_PAD_EN defined, 4-byte frame 0x04030201 last -> 15 beats (4 data + 56 zero bytes), then one FCS beat kF tlast matching the reference CRC over 60 bytes.
